// File: rtl/point4_fft_pkg.sv
// point4_fft_pkg: shared widths, frame length and FSM states for the point4 FFT/IFFT blocks.
package point4_fft_pkg;
    localparam int PTS   = 4;
    localparam int N_DEF = 8;
    function automatic int iw(input int n);
        return n + 1;
    endfunction
    function automatic int ow(input int n);
        return n + 3;
    endfunction
    localparam int IW = iw(N_DEF);
    localparam int OW = ow(N_DEF);
    typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;
endpackage

// File: rtl/point4_ifft_bfly.sv
// point4_ifft_bfly: combinational radix-4 inverse butterfly.
// POINT4_IFFT_SCALE_EN divides every result by 4 (floor), giving a true IFFT.
module point4_ifft_bfly
    import point4_fft_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int WI = iw(N),
    localparam int WO = ow(N)
) (
    input  logic signed [WI-1:0] x_re_i [PTS],
    input  logic signed [WI-1:0] x_im_i [PTS],
    output logic signed [WO-1:0] y_re_o [PTS],
    output logic signed [WO-1:0] y_im_o [PTS]
);
    logic signed [WO-1:0] xr [PTS];
    logic signed [WO-1:0] xi [PTS];
    logic signed [WO-1:0] ar, ai, br, bi, cr, ci, dr, di;

    function automatic logic signed [WO-1:0] scl(input logic signed [WO-1:0] v);
`ifdef POINT4_IFFT_SCALE_EN
        return v >>> 2;
`else
        return v;
`endif
    endfunction

    always_comb begin
        for (int k = 0; k < PTS; k++) begin
            xr[k] = WO'(x_re_i[k]);
            xi[k] = WO'(x_im_i[k]);
        end
        ar = xr[0] + xr[2];
        ai = xi[0] + xi[2];
        br = xr[0] - xr[2];
        bi = xi[0] - xi[2];
        cr = xr[1] + xr[3];
        ci = xi[1] + xi[3];
        dr = xr[1] - xr[3];
        di = xi[1] - xi[3];
        // odd outputs rotate d by +j (x1) and -j (x3)
        y_re_o[0] = scl(ar + cr);
        y_im_o[0] = scl(ai + ci);
        y_re_o[1] = scl(br - di);
        y_im_o[1] = scl(bi + dr);
        y_re_o[2] = scl(ar - cr);
        y_im_o[2] = scl(ai - ci);
        y_re_o[3] = scl(br + di);
        y_im_o[3] = scl(bi - dr);
    end
endmodule

// File: rtl/point4_ifft_stream.sv
// point4_ifft_stream: streaming 4-point IFFT; loads 4 bins, one butterfly cycle, emits 4 samples.
// Define POINT4_IFFT_SCALE_EN to divide results by 4 (true IFFT); default output is 4x the IFFT.
module point4_ifft_stream
    import point4_fft_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int WI = iw(N),
    localparam int WO = ow(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WI-1:0] in_re,
    input  logic signed [WI-1:0] in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WO-1:0] out_re,
    output logic signed [WO-1:0] out_im,
    output logic                 out_last
);
    state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d, ocnt_q, ocnt_d;
    logic signed [WI-1:0] xr_q [PTS];
    logic signed [WI-1:0] xi_q [PTS];
    logic signed [WO-1:0] yr_q [PTS];
    logic signed [WO-1:0] yi_q [PTS];
    logic signed [WO-1:0] yr_d [PTS];
    logic signed [WO-1:0] yi_d [PTS];
    logic in_hs, out_hs;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    point4_ifft_bfly #(.N(N)) u_bfly (
        .x_re_i(xr_q),
        .x_im_i(xi_q),
        .y_re_o(yr_d),
        .y_im_o(yi_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    // 2-bit counters wrap to 0 on the 4th handshake
    always_comb begin
        state_d = state_q == LOAD ? ((in_hs && cnt_q == 2'd3) ? CALC : LOAD) :
                  state_q == CALC ? SEND :
                  ((out_hs && ocnt_q == 2'd3) ? LOAD : SEND);
        cnt_d   = cnt_q + 2'(in_hs);
        ocnt_d  = ocnt_q + 2'(out_hs);
    end

    always_comb begin
        in_ready  = state_q == LOAD;
        out_valid = state_q == SEND;
        out_last  = out_valid && ocnt_q == 2'd3;
        out_re    = out_valid ? yr_q[ocnt_q] : '0;
        out_im    = out_valid ? yi_q[ocnt_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ocnt_q <= '0;
            for (int k = 0; k < PTS; k++) begin
                xr_q[k] <= '0;
                xi_q[k] <= '0;
                yr_q[k] <= '0;
                yi_q[k] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            ocnt_q <= ocnt_d;
            if (in_hs) begin
                xr_q[cnt_q] <= in_re;
                xi_q[cnt_q] <= in_im;
            end
            if (state_q == CALC) begin
                yr_q <= yr_d;
                yi_q <= yi_d;
            end
        end
    end
endmodule
